// File: rtl/hdr_pkg.sv
// -----------------------------------------------------------------------------
// hdr_pkg
// Shared types and constants for the arrow game-play datapath.
//   state_t         : game FSM states (IDLE / PLAY / PAUSE / OVER)
//   LANE_*          : lane encoding, matching the dir_in bit order
//   LFSR_SEED/TAPS  : spawn-lane LFSR reset value and Galois tap mask
//   SCORE_W         : width of the saturating score
//   lfsr_step       : one Galois step (taps 16,14,13,11)
//   lfsr_lane       : lane picked from the value after one step
// -----------------------------------------------------------------------------
package hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] LANE_UP    = 2'd0;
    localparam logic [1:0] LANE_DOWN  = 2'd1;
    localparam logic [1:0] LANE_LEFT  = 2'd2;
    localparam logic [1:0] LANE_RIGHT = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form: bits 15,13,12,10 realise taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int                 SCORE_W   = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    function automatic logic [1:0] lfsr_lane(input logic [15:0] cur);
        lfsr_lane = 2'(lfsr_step(cur));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used to pick the lane of each new arrow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads LFSR_SEED)
//   en         : advance one step this cycle
//   state      : current LFSR value
// -----------------------------------------------------------------------------
module lfsr16
    import hdr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] lfsr_r;

    // LFSR register: holds unless enabled, then takes one Galois step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (en) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/arrow_sequencer.sv
// -----------------------------------------------------------------------------
// arrow_sequencer
// Game-play controller: spawns falling arrows, judges player presses against
// the hit line, counts score and misses, and owns the IDLE/PLAY/PAUSE/OVER FSM.
// All game state advances once per frame_tick while in PLAY.
// Build option: define MISS_PENALTY_EN to make an unmatched press cost one
// point (floor 0) and raise miss_pulse; otherwise unmatched presses are ignored.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   frame_tick      : one-cycle pulse per video frame
//   start_btn       : start / back-to-idle pulse
//   pause_btn       : pause toggle pulse
//   dir_in[3:0]     : player direction levels (up, down, left, right)
//   slot_valid      : per-slot live flag
//   slot_lane       : packed 2-bit lane per slot
//   slot_y          : packed 10-bit y per slot
//   target_arrow    : lanes with a live arrow inside the hit window
//   score           : saturating hit count
//   pause_state     : high while paused
//   game_over       : high in OVER
//   hit_pulse       : one cycle after a frame with at least one hit
//   miss_pulse      : one cycle after a frame with at least one miss
// -----------------------------------------------------------------------------
module arrow_sequencer
    import hdr_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPAWN_PERIOD = 60,
    parameter int SPEED        = 4,
    parameter int HIT_Y        = 400,
    parameter int HIT_WIN      = 16,
    parameter int SCREEN_H     = 480,
    parameter int MAX_MISSES   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic                    start_btn,
    input  logic                    pause_btn,
    input  logic [3:0]              dir_in,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [2*NUM_SLOTS-1:0]  slot_lane,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic [3:0]              target_arrow,
    output logic [SCORE_W-1:0]      score,
    output logic                    pause_state,
    output logic                    game_over,
    output logic                    hit_pulse,
    output logic                    miss_pulse
);

    localparam int FC_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    state_t                    state_r, state_next_s;
    logic [NUM_SLOTS-1:0]      valid_r, valid_next_s;
    logic [NUM_SLOTS-1:0][1:0] lane_r, lane_next_s;
    logic [NUM_SLOTS-1:0][9:0] y_r, y_next_s;
    logic [SCORE_W-1:0]        score_r, score_next_s;
    logic [MISS_W-1:0]         misses_r, misses_next_s;
    logic [FC_W-1:0]           fc_r, fc_next_s;
    logic [3:0]                dir_prev_r, pending_r, pending_next_s, rise_s;
    logic                      hit_r, hit_next_s, miss_r, miss_next_s;
    logic                      pause_r, over_r, frame_s, found_s, spawn_done_s;
    logic                      lfsr_en_s;
    logic [15:0]               lfsr_state_s;
    logic [NUM_SLOTS-1:0]      hit_mask_s;
    logic [7:0]                hit_cnt_s, miss_cnt_s, score_sum_s, miss_sum_s;
    logic [10:0]               y_moved_s;
`ifdef MISS_PENALTY_EN
    logic [7:0]                pen_cnt_s;
`endif

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en_s),
        .state (lfsr_state_s)
    );

    // Window test done in 11 bits so y near 0 cannot underflow.
    function automatic logic in_window(input logic [9:0] y);
        in_window = (({1'b0, y} + 11'(HIT_WIN)) >= 11'(HIT_Y)) &&
                    ({1'b0, y} <= 11'(HIT_Y + HIT_WIN));
    endfunction

    // FSM next state plus the per-frame judge / move / miss / spawn update
    always_comb begin
        rise_s         = dir_in & ~dir_prev_r;
        state_next_s   = state_r;
        valid_next_s   = valid_r;
        lane_next_s    = lane_r;
        y_next_s       = y_r;
        score_next_s   = score_r;
        misses_next_s  = misses_r;
        fc_next_s      = fc_r;
        hit_next_s     = 1'b0;
        miss_next_s    = 1'b0;
        lfsr_en_s      = 1'b0;
        frame_s        = 1'b0;
        found_s        = 1'b0;
        spawn_done_s   = 1'b0;
        hit_mask_s     = '0;
        hit_cnt_s      = 8'd0;
        miss_cnt_s     = 8'd0;
        score_sum_s    = 8'd0;
        miss_sum_s     = 8'd0;
        y_moved_s      = 11'd0;
        pending_next_s = 4'd0;
`ifdef MISS_PENALTY_EN
        pen_cnt_s      = 8'd0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_btn) begin
                    state_next_s  = ST_PLAY;
                    valid_next_s  = '0;
                    lane_next_s   = '0;
                    y_next_s      = '0;
                    score_next_s  = '0;
                    misses_next_s = '0;
                    fc_next_s     = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (pause_btn) begin
                    state_next_s = ST_PAUSE;
                end else if (frame_tick) begin
                    frame_s = 1'b1;
                    // Judge: per pressed lane, free the lowest matching in-window slot.
                    for (int l = int'(LANE_UP); l <= int'(LANE_RIGHT); l++) begin
                        found_s = 1'b0;
                        if (pending_r[l]) begin
                            for (int s = 0; s < NUM_SLOTS; s++) begin
                                if (!found_s && valid_r[s] && (lane_r[s] == 2'(l)) &&
                                    in_window(y_r[s])) begin
                                    found_s       = 1'b1;
                                    hit_mask_s[s] = 1'b1;
                                end else begin
                                    found_s = found_s;
                                end
                            end
                            if (found_s) begin
                                hit_cnt_s = hit_cnt_s + 8'd1;
                            end else begin
`ifdef MISS_PENALTY_EN
                                pen_cnt_s = pen_cnt_s + 8'd1;
`else
                                hit_cnt_s = hit_cnt_s;
`endif
                            end
                        end else begin
                            found_s = 1'b0;
                        end
                    end
                    // Move survivors, then retire anything that fell off screen.
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (hit_mask_s[s]) begin
                            valid_next_s[s] = 1'b0;
                            y_next_s[s]     = 10'd0;
                        end else if (valid_r[s]) begin
                            y_moved_s = {1'b0, y_r[s]} + 11'(SPEED);
                            if (y_moved_s >= 11'(SCREEN_H)) begin
                                valid_next_s[s] = 1'b0;
                                y_next_s[s]     = 10'd0;
                                miss_cnt_s      = miss_cnt_s + 8'd1;
                            end else begin
                                y_next_s[s] = y_moved_s[9:0];
                            end
                        end else begin
                            y_next_s[s] = y_r[s];
                        end
                    end
                    score_sum_s  = 8'(score_r) + hit_cnt_s;
                    score_next_s = (score_sum_s > 8'(SCORE_MAX)) ? SCORE_MAX
                                                                 : score_sum_s[SCORE_W-1:0];
                    hit_next_s   = |hit_mask_s;
                    miss_next_s  = (miss_cnt_s != 8'd0);
`ifdef MISS_PENALTY_EN
                    score_next_s = (8'(score_next_s) > pen_cnt_s)
                                   ? (score_next_s - pen_cnt_s[SCORE_W-1:0]) : '0;
                    miss_next_s  = miss_next_s || (pen_cnt_s != 8'd0);
`endif
                    miss_sum_s    = 8'(misses_r) + miss_cnt_s;
                    misses_next_s = (miss_sum_s >= 8'(MAX_MISSES)) ? MISS_W'(MAX_MISSES)
                                                                   : miss_sum_s[MISS_W-1:0];
                    // Spawn only into a slot that was already free before judging.
                    if (fc_r == FC_W'(SPAWN_PERIOD - 1)) begin
                        fc_next_s = '0;
                        lfsr_en_s = 1'b1;
                        for (int s = 0; s < NUM_SLOTS; s++) begin
                            if (!spawn_done_s && !valid_r[s]) begin
                                spawn_done_s    = 1'b1;
                                valid_next_s[s] = 1'b1;
                                lane_next_s[s]  = lfsr_lane(lfsr_state_s);
                                y_next_s[s]     = 10'd0;
                            end else begin
                                spawn_done_s = spawn_done_s;
                            end
                        end
                    end else begin
                        fc_next_s = fc_r + FC_W'(1);
                    end
                    if (miss_sum_s >= 8'(MAX_MISSES)) begin
                        state_next_s = ST_OVER;
                        valid_next_s = '0;
                        lane_next_s  = '0;
                        y_next_s     = '0;
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (pause_btn) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OVER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // Presses only accumulate while staying in PLAY; a frame consumes them.
        if ((state_r == ST_PLAY) && (state_next_s == ST_PLAY)) begin
            pending_next_s = frame_s ? rise_s : (pending_r | rise_s);
        end else begin
            pending_next_s = 4'd0;
        end
    end

    // Game state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            valid_r  <= '0;
            lane_r   <= '0;
            y_r      <= '0;
            score_r  <= '0;
            misses_r <= '0;
            fc_r     <= '0;
        end else begin
            state_r  <= state_next_s;
            valid_r  <= valid_next_s;
            lane_r   <= lane_next_s;
            y_r      <= y_next_s;
            score_r  <= score_next_s;
            misses_r <= misses_next_s;
            fc_r     <= fc_next_s;
        end
    end

    // Press edge detection and pending-press capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_prev_r <= 4'd0;
            pending_r  <= 4'd0;
        end else begin
            dir_prev_r <= dir_in;
            pending_r  <= pending_next_s;
        end
    end

    // Registered status flags and per-frame pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
            pause_r <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            hit_r   <= hit_next_s;
            miss_r  <= miss_next_s;
            pause_r <= (state_next_s == ST_PAUSE);
            over_r  <= (state_next_s == ST_OVER);
        end
    end

    // Lanes with a live arrow currently inside the hit window
    always_comb begin
        target_arrow = 4'd0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (valid_r[s] && in_window(y_r[s])) begin
                target_arrow[lane_r[s]] = 1'b1;
            end else begin
                target_arrow = target_arrow;
            end
        end
    end

    assign slot_valid  = valid_r;
    assign slot_lane   = lane_r;
    assign slot_y      = y_r;
    assign score       = score_r;
    assign pause_state = pause_r;
    assign game_over   = over_r;
    assign hit_pulse   = hit_r;
    assign miss_pulse  = miss_r;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Self-checking bench for arrow_sequencer against a behavioural game model.
module tb_arrow_sequencer;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, start_btn, pause_btn;
    logic [3:0]  dir_in;
    logic [3:0]  slot_valid;
    logic [7:0]  slot_lane;
    logic [39:0] slot_y;
    logic [3:0]  target_arrow;
    logic [5:0]  score;
    logic        pause_state, game_over, hit_pulse, miss_pulse;

    arrow_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .dir_in       (dir_in),
        .slot_valid   (slot_valid),
        .slot_lane    (slot_lane),
        .slot_y       (slot_y),
        .target_arrow (target_arrow),
        .score        (score),
        .pause_state  (pause_state),
        .game_over    (game_over),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 idle, 1 play, 2 pause, 3 over
    int m_state;
    int m_valid[NS];
    int m_lane[NS];
    int m_y[NS];
    int m_score, m_misses, m_fc, m_lfsr, m_hit, m_miss, m_pending, m_prev_dir;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(int y);
        return (y >= 400 - 16) && (y <= 400 + 16);
    endfunction

    function automatic int model_targets();
        int t;
        t = 0;
        for (int s = 0; s < NS; s++)
            if (m_valid[s] != 0 && in_win(m_y[s])) t = t | (1 << m_lane[s]);
        return t;
    endfunction

    task automatic clear_slots();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 0;
            m_lane[s]  = 0;
            m_y[s]     = 0;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_misses = 0; m_fc = 0; m_lfsr = 'hACE1;
        m_hit = 0; m_miss = 0; m_pending = 0; m_prev_dir = 0;
        clear_slots();
    endtask

    task automatic model_step(input int frame, input int start, input int pause, input int dir);
        int rise, old_state, do_frame, hits, pens, found, slot;
        int free_before[NS];
        rise = dir & ~m_prev_dir & 15;
        m_prev_dir = dir;
        m_hit = 0; m_miss = 0; do_frame = 0;
        old_state = m_state;
        case (m_state)
            0: if (start != 0) begin
                   m_state = 1; m_score = 0; m_misses = 0; m_fc = 0;
                   clear_slots();
               end
            1: if (pause != 0) m_state = 2;
               else if (frame != 0) do_frame = 1;
            2: if (pause != 0) m_state = 1;
            default: if (start != 0) m_state = 0;
        endcase
        if (do_frame != 0) begin
            for (int s = 0; s < NS; s++) free_before[s] = (m_valid[s] == 0);
            hits = 0; pens = 0;
            for (int l = 0; l < 4; l++) begin
                if (((m_pending >> l) & 1) != 0) begin
                    found = 0;
                    for (int s = 0; s < NS; s++) begin
                        if (found == 0 && m_valid[s] != 0 && m_lane[s] == l && in_win(m_y[s])) begin
                            found = 1; m_valid[s] = 0; m_y[s] = 0; hits++;
                        end
                    end
                    if (found == 0) pens++;
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (m_valid[s] != 0) begin
                    m_y[s] += 4;
                    if (m_y[s] >= 480) begin
                        m_valid[s] = 0; m_y[s] = 0; m_misses++; m_miss = 1;
                    end
                end
            end
            if (hits > 0) m_hit = 1;
            m_score = (m_score + hits > 63) ? 63 : m_score + hits;
`ifdef MISS_PENALTY_EN
            m_score = (m_score > pens) ? m_score - pens : 0;
            if (pens > 0) m_miss = 1;
`endif
            if (m_misses > 8) m_misses = 8;
            if (m_fc == 59) begin
                m_fc = 0;
                m_lfsr = ((m_lfsr & 1) != 0) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
                slot = -1;
                for (int s = 0; s < NS; s++) if (slot < 0 && free_before[s] != 0) slot = s;
                if (slot >= 0) begin
                    m_valid[slot] = 1; m_lane[slot] = m_lfsr & 3; m_y[slot] = 0;
                end
            end else begin
                m_fc++;
            end
            if (m_misses >= 8) begin
                m_state = 3;
                clear_slots();
            end
        end
        if (old_state == 1 && m_state == 1) m_pending = (do_frame != 0) ? rise : (m_pending | rise);
        else m_pending = 0;
    endtask

    task automatic check_outputs();
        logic [3:0]  ev, et;
        logic [7:0]  el;
        logic [39:0] ey;
        ev = '0; et = '0; el = '0; ey = '0;
        for (int s = 0; s < NS; s++) begin
            ev[s]          = (m_valid[s] != 0);
            el[2*s +: 2]   = 2'(m_lane[s]);
            ey[10*s +: 10] = 10'(m_y[s]);
            if (m_valid[s] != 0 && in_win(m_y[s])) et[m_lane[s]] = 1'b1;
        end
        check_val("slot_valid", 64'(slot_valid), 64'(ev));
        check_val("slot_lane", 64'(slot_lane), 64'(el));
        check_val("slot_y", 64'(slot_y), 64'(ey));
        check_val("target_arrow", 64'(target_arrow), 64'(et));
        check_val("score", 64'(score), 64'(m_score));
        check_val("pause_state", 64'(pause_state), 64'(m_state == 2));
        check_val("game_over", 64'(game_over), 64'(m_state == 3));
        check_val("hit_pulse", 64'(hit_pulse), 64'(m_hit));
        check_val("miss_pulse", 64'(miss_pulse), 64'(m_miss));
    endtask

    task automatic step(input int frame, input int start, input int pause, input int dir);
        @(negedge clk);
        frame_tick = 1'(frame);
        start_btn  = 1'(start);
        pause_btn  = 1'(pause);
        dir_in     = 4'(dir);
        model_step(frame, start, pause, dir);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        pause_btn  = 1'b0;
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, got;
        logic [39:0] saved_y;
        rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; dir_in = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // First game: spawn timing, then reset with two live arrows.
        step(0, 1, 0, 0);
        repeat (60) step(1, 0, 0, 0);
        check_val("spawn0_valid", 64'(slot_valid[0]), 64'd1);
        check_val("spawn0_lane", 64'(slot_lane[1:0]), 64'd0);
        repeat (70) step(1, 0, 0, 0);
        check_val("two_live", 64'(slot_valid), 64'h3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_valid", 64'(slot_valid), 64'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 0);

        // Second game from the seed: arrow reaches the hit line.
        step(0, 1, 0, 0);
        repeat (60) step(1, 0, 0, 0);
        check_val("reseed_lane", 64'(slot_lane[1:0]), 64'd0);
        check_val("reseed_y", 64'(slot_y[9:0]), 64'd0);
        repeat (100) step(1, 0, 0, 0);
        check_val("hitline_y", 64'(slot_y[9:0]), 64'd400);
        check_val("hitline_target", 64'(target_arrow[0]), 64'd1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        check_val("hit_score", 64'(score), 64'd1);
        check_val("hit_pulse_on", 64'(hit_pulse), 64'd1);
        check_val("hit_freed", 64'(slot_valid[0]), 64'd0);
        step(0, 0, 0, 0);
        check_val("hit_pulse_off", 64'(hit_pulse), 64'd0);
        step(0, 0, 0, 8);
        step(1, 0, 0, 0);
`ifdef MISS_PENALTY_EN
        check_val("wrong_lane_score", 64'(score), 64'd0);
`else
        check_val("wrong_lane_score", 64'(score), 64'd1);
`endif

        // Pause freezes everything and discards presses.
        step(0, 0, 1, 0);
        check_val("paused", 64'(pause_state), 64'd1);
        saved_y = '0;
        for (int s = 0; s < NS; s++) saved_y[10*s +: 10] = 10'(m_y[s]);
        repeat (200) step(1, 0, 0, int'($urandom_range(0, 15)));
        check_val("pause_frozen_y", 64'(slot_y), 64'(saved_y));
        step(0, 0, 1, 0);
        check_val("resumed", 64'(pause_state), 64'd0);
        step(0, 1, 1, 0);
        check_val("start_pause_play", 64'(pause_state), 64'd1);
        step(0, 1, 1, 0);
        check_val("start_pause_resume", 64'(pause_state), 64'd0);

        // Model-guided player drives score to saturation.
        for (int it = 0; it < 6000 && m_score < 63 && m_state == 1; it++) begin
            t = model_targets();
            if (t != 0 && $urandom_range(0, 3) != 0) begin
                step(0, 0, 0, t);
            end else begin
                step(0, 0, 0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0);
            end
            step(1, 0, 0, 0);
        end
        check_val("score_reach_63", 64'(score), 64'd63);
        got = 0;
        for (int it = 0; it < 300 && got == 0; it++) begin
            t = model_targets();
            if (t != 0) begin
                step(0, 0, 0, t);
                step(1, 0, 0, 0);
                check_val("sat_score", 64'(score), 64'd63);
                check_val("sat_hit_pulse", 64'(hit_pulse), 64'd1);
                got = 1;
            end else begin
                step(1, 0, 0, 0);
            end
        end
        check_val("sat_hit_seen", 64'(got), 64'd1);

        // Idle player: misses accumulate until game over.
        for (int it = 0; it < 3000 && m_state != 3; it++) step(1, 0, 0, 0);
        check_val("over_flag", 64'(game_over), 64'd1);
        check_val("over_slots", 64'(slot_valid), 64'd0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check_val("idle_after_over", 64'(game_over), 64'd0);
        check_val("idle_score_held", 64'(score), 64'd63);
        step(0, 1, 0, 0);
        check_val("new_game_score", 64'(score), 64'd0);

        // Free-running random stimulus.
        for (int it = 0; it < 600; it++) begin
            step(int'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0) ? 1 : 0,
                 ($urandom_range(0, 40) == 0) ? 1 : 0, int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arrow_sequencer.md
Name: arrow_sequencer

Overview:
- Game-play controller for the arrow display datapath. It sequences falling arrows, judges player hits, keeps score and owns pause/game-over state.
- Its outputs feed the per-pixel arrow renderer and the pixel colouring stage: `target_arrow`, `score` and `pause_state`.
- It updates once per video frame, on `frame_tick`.

Parameters:
- NUM_SLOTS, 4, maximum simultaneous in-flight arrows.
- SPAWN_PERIOD, 60, frames between spawn attempts.
- SPEED, 4, pixels an arrow falls per frame.
- HIT_Y, 400, y coordinate of the hit line.
- HIT_WIN, 16, hit accepted when |y - HIT_Y| <= HIT_WIN.
- SCREEN_H, 480, y at or beyond which an arrow counts as missed.
- MAX_MISSES, 8, misses that end the game.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vsync)
- start_btn  in  1  debounced one-cycle pulse
- pause_btn  in  1  debounced one-cycle pulse
- dir_in  in  4  player direction, level; bit0 up, bit1 down, bit2 left, bit3 right
- slot_valid  out  NUM_SLOTS  slot holds a live arrow
- slot_lane  out  2*NUM_SLOTS  packed lane index per slot
- slot_y  out  10*NUM_SLOTS  packed y per slot
- target_arrow  out  4  lanes that currently have a live arrow inside the hit window
- score  out  6  saturating hit count
- pause_state  out  1  high in PAUSE
- game_over  out  1  high in OVER
- hit_pulse  out  1  one cycle per frame with at least one hit
- miss_pulse  out  1  one cycle per frame with at least one miss

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; all slots invalid, lane 0, y 0; score=0; miss count=0; frame counter=0; LFSR=16'hACE1; all outputs 0.
- FSM states: IDLE, PLAY, PAUSE, OVER.
  - IDLE: start_btn -> PLAY; score, misses, slots and frame counter cleared.
  - PLAY: pause_btn -> PAUSE; miss count reaching MAX_MISSES -> OVER, effective at the same update.
  - PAUSE: pause_btn -> PLAY. Slots, counters and LFSR are frozen.
  - OVER: start_btn -> IDLE. Slots cleared; score held until IDLE->PLAY.
  - If start and pause arrive in the same cycle, only the button relevant to the current state acts.
- Press capture:
  - Per-clock rising-edge detect on each dir_in bit, ORed into a 4-bit pending register.
  - Pending is consumed and cleared at the next frame_tick in PLAY.
  - Pending is cleared (discarded) on any state change and throughout PAUSE/IDLE/OVER.
- Frame update (frame_tick in PLAY; results visible the cycle after the tick), in this order:
  1. Judge:
     - For each pending lane L, the lowest-index valid slot with lane L and pre-move y in window is freed.
     - Score increments by 1 per freed slot, saturating at 63.
     - hit_pulse is asserted if any slot is freed.
     - At most one slot is freed per lane per frame.
  2. Move: every remaining valid slot gets y += SPEED, computed 11-bit to avoid wrap.
  3. Miss:
     - Any slot with new y >= SCREEN_H is freed.
     - Miss count increments per freed slot, saturating at MAX_MISSES.
     - miss_pulse is asserted if any slot is freed.
  4. Spawn:
     - Frame counter = SPAWN_PERIOD-1 -> counter reloads to 0 and the LFSR advances (Galois, taps 16,14,13,11).
     - The lowest-index slot free before step 1 is loaded with lane = new LFSR[1:0] and y = 0.
     - If no slot is free, the spawn is dropped silently.
     - Otherwise the counter increments.
- target_arrow: combinational from registered slots; bit L is set if any valid slot with lane L has y in window.
- Slot outputs are registered; freed slots reset y to 0.

Optional Feature:
- MISS_PENALTY_EN: a pending press whose lane matches no in-window slot decrements score (saturating at 0) and asserts miss_pulse. It does not affect the miss count.
- Without MISS_PENALTY_EN: unmatched presses are ignored.

Decomposition:
- Shared package `hdr_pkg`: state enum (IDLE/PLAY/PAUSE/OVER), lane encoding constants (UP=0, DOWN=1, LEFT=2, RIGHT=3), LFSR seed and tap mask, score width.
- One natural sub-module: `lfsr16` (enable, seed on reset, 16-bit state out).

Test Plan:
- Reset mid-PLAY with 2 live slots -> next cycle all outputs 0, state IDLE, LFSR=16'hACE1.
- start_btn, then 60 frame_ticks -> slot0 valid, y=0, lane = LFSR[1:0] after one advance from seed; after 100 further ticks slot0 y=400 and its target_arrow bit set.
- Press matching lane when y=400 -> slot freed, score 0->1, hit_pulse one cycle. Press wrong lane -> score unchanged (penalty build: score stays 0 when already 0, miss_pulse asserted).
- No presses for a long run -> each arrow freed at y=480 with miss_pulse; 8th miss -> game_over=1; start_btn -> IDLE.
- pause_btn in PLAY -> pause_state=1; 200 frame_ticks -> slot_y unchanged; pause_btn -> resume from the same positions.
- Score preloaded to 63 via hits, then another hit -> score stays 63, hit_pulse still asserted.
